// File: rtl/reservation_station_array_pkg.sv
// rtl/reservation_station_array_pkg.sv - shared types for the reservation station array
// Entry, CDB and control-bit layouts plus the operand wakeup helper.
`ifndef RS_SIZE
`define RS_SIZE 8
`endif

package reservation_station_array_pkg;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int AGE_W  = 6;

  typedef logic [AGE_W-1:0]  rs_age_t;
  typedef logic [TAG_W-1:0]  rs_tag_t;
  typedef logic [DATA_W-1:0] rs_data_t;

  localparam rs_age_t AGE_MAX = '1;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       is_branch;
  } control_bits;

  typedef struct packed {
    logic        busy;
    control_bits ctrl_bits;
    rs_tag_t     tag;
    rs_tag_t     tag_1;
    rs_tag_t     tag_2;
    rs_data_t    value_1;
    rs_data_t    value_2;
    rs_data_t    imm;
  } rs_entry;

  typedef struct packed {
    rs_tag_t  tag;
    rs_data_t value;
  } cdb;

  // Resolve any pending operand that one of the broadcasts satisfies; cdb c1 wins ties.
  function automatic rs_entry rs_snoop(input rs_entry e, input cdb c1, input cdb c2);
    rs_entry r;
    r = e;
    if (r.tag_1 != '0) begin
      if (r.tag_1 == c1.tag) begin
        r.value_1 = c1.value;
        r.tag_1   = '0;
      end else if (r.tag_1 == c2.tag) begin
        r.value_1 = c2.value;
        r.tag_1   = '0;
      end
    end
    if (r.tag_2 != '0) begin
      if (r.tag_2 == c1.tag) begin
        r.value_2 = c1.value;
        r.tag_2   = '0;
      end else if (r.tag_2 == c2.tag) begin
        r.value_2 = c2.value;
        r.tag_2   = '0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_array_rs_oldest_select.sv
// rtl/reservation_station_array_rs_oldest_select.sv - oldest-ready picker
// Pairwise reduction tree over ready slots; larger age wins, ties go to the lower index.
module rs_oldest_select
  import reservation_station_array_pkg::*;
#(
  parameter int N = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                ready [N],
  input  rs_age_t             ages  [N],
  output logic                found,
  output logic [IDX_W-1:0]    index
);

  localparam int LEVELS = $clog2(N);
  localparam int W      = 1 << LEVELS;

  logic    [LEVELS:0][W-1:0]            v;
  rs_age_t [LEVELS:0][W-1:0]            a;
  logic    [LEVELS:0][W-1:0][IDX_W-1:0] ix;

  always_comb begin
    v  = '0;
    a  = '0;
    ix = '0;
    for (int i = 0; i < N; i++) begin
      v[0][i]  = ready[i];
      a[0][i]  = ages[i];
      ix[0][i] = IDX_W'(i);
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < (W >> (l + 1)); i++) begin
        // The right (higher-index) leg only wins on a strictly greater age.
        if (v[l][2*i+1] && (!v[l][2*i] || (a[l][2*i+1] > a[l][2*i]))) begin
          v[l+1][i]  = 1'b1;
          a[l+1][i]  = a[l][2*i+1];
          ix[l+1][i] = ix[l][2*i+1];
        end else begin
          v[l+1][i]  = v[l][2*i];
          a[l+1][i]  = a[l][2*i];
          ix[l+1][i] = ix[l][2*i];
        end
      end
    end
    found = v[LEVELS][0];
    index = ix[LEVELS][0];
  end

endmodule

// File: rtl/reservation_station_array.sv
// rtl/reservation_station_array.sv - reservation station slots with CDB wakeup and oldest-first issue
// Accepts one dispatch and issues one instruction per cycle through a valid/ready output register.
module reservation_station_array
  import reservation_station_array_pkg::*;
#(
  parameter int RS_SIZE = `RS_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dispatch_valid,
  input  rs_entry               dispatch_entry,
  input  logic [31:0]           dispatch_station_id,
  input  cdb                    cdb1,
  input  cdb                    cdb2,
  input  logic                  flush,
  input  logic                  issue_ready,
  output logic                  issue_valid,
  output rs_entry               issue_entry,
  output rs_entry [RS_SIZE-1:0] res_stations,
  output logic                  rs_full,
  output logic                  dispatch_err
);

  localparam int IDX_W = $clog2(RS_SIZE);

  rs_entry [RS_SIZE-1:0] slots_q, slots_d;
  rs_age_t [RS_SIZE-1:0] ages_q, ages_d;
  logic                  issue_valid_q, issue_valid_d;
  rs_entry               issue_entry_q, issue_entry_d;
  logic                  rs_full_q, rs_full_d;
  logic                  dispatch_err_q, dispatch_err_d;

  logic                  ready [RS_SIZE];
  rs_age_t               ages_arr [RS_SIZE];
  logic [RS_SIZE-1:0]    busy_d;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic                  do_issue;
  logic                  disp_ok;
  logic [IDX_W-1:0]      disp_idx;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i]    = slots_q[i].busy && (slots_q[i].tag_1 == '0) && (slots_q[i].tag_2 == '0);
      ages_arr[i] = ages_q[i];
    end
  end

  rs_oldest_select #(.N(RS_SIZE)) u_select (
    .ready (ready),
    .ages  (ages_arr),
    .found (sel_found),
    .index (sel_idx)
  );

  always_comb begin
    disp_idx       = dispatch_station_id[IDX_W-1:0];
    // A slot being freed this edge is still busy in slots_q, so it is rejected here too.
    disp_ok        = dispatch_valid && (dispatch_station_id < 32'(RS_SIZE)) && !slots_q[disp_idx].busy;
    do_issue       = sel_found && (!issue_valid_q || issue_ready);
    slots_d        = slots_q;
    ages_d         = ages_q;
    issue_valid_d  = issue_valid_q;
    issue_entry_d  = issue_entry_q;
    dispatch_err_d = dispatch_err_q;

    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        slots_d[i].busy = 1'b0;
      end
      ages_d        = '0;
      issue_valid_d = 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (slots_q[i].busy) begin
          slots_d[i] = rs_snoop(slots_q[i], cdb1, cdb2);
          ages_d[i]  = (ages_q[i] == AGE_MAX) ? AGE_MAX : ages_q[i] + rs_age_t'(1);
        end
      end
      if (do_issue) begin
        issue_entry_d         = slots_q[sel_idx];
        issue_valid_d         = 1'b1;
        slots_d[sel_idx].busy = 1'b0;
        ages_d[sel_idx]       = '0;
      end else if (issue_ready) begin
        issue_valid_d = 1'b0;
      end
      if (disp_ok) begin
        slots_d[disp_idx]      = rs_snoop(dispatch_entry, cdb1, cdb2);
        slots_d[disp_idx].busy = 1'b1;
        ages_d[disp_idx]       = '0;
      end else if (dispatch_valid) begin
        dispatch_err_d = 1'b1;
      end
    end

    for (int i = 0; i < RS_SIZE; i++) begin
      busy_d[i] = slots_d[i].busy;
    end
    rs_full_d = &busy_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slots_q        <= '0;
      ages_q         <= '0;
      issue_valid_q  <= 1'b0;
      issue_entry_q  <= '0;
      rs_full_q      <= 1'b0;
      dispatch_err_q <= 1'b0;
    end else begin
      slots_q        <= slots_d;
      ages_q         <= ages_d;
      issue_valid_q  <= issue_valid_d;
      issue_entry_q  <= issue_entry_d;
      rs_full_q      <= rs_full_d;
      dispatch_err_q <= dispatch_err_d;
    end
  end

  assign issue_valid  = issue_valid_q;
  assign issue_entry  = issue_entry_q;
  assign res_stations = slots_q;
  assign rs_full      = rs_full_q;
  assign dispatch_err = dispatch_err_q;

endmodule
